// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for the (N+1)-bit up-counter datapath.
// The host issues START/STOP/PAUSE/RESUME over a valid/ready handshake.
// START latches a terminal limit and a periodic/one-shot mode.
// The block then steps count from 0 to limit.
// Each terminal event pulses done and increments the periods counter.
//
// Ports:
//   clock        in   single clock, all state updates on posedge
//   rst          in   asynchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  command can be accepted this cycle (low only in LOAD)
//   cmd_op       in   00 START, 01 STOP, 10 PAUSE, 11 RESUME
//   cmd_limit    in   terminal value, sampled on an accepted START
//   cmd_periodic in   1 = periodic, 0 = one-shot, sampled on an accepted START
//   count        out  current count value (registered)
//   busy         out  high in LOAD, RUN or PAUSE
//   done         out  one-cycle pulse on a terminal event
//   periods      out  completed periods since last START, wraps 255 -> 0
module counter_ctrl #(
  parameter int unsigned N = 7
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N:0]   cmd_limit,
  input  logic         cmd_periodic,
  output logic [N:0]   count,
  output logic         busy,
  output logic         done,
  output logic [7:0]   periods
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_PAUSE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_STOP   = 2'b01,
    OP_PAUSE  = 2'b10,
    OP_RESUME = 2'b11
  } op_e;

  state_e     state_q, state_d;
  logic [N:0] count_q, count_d;
  logic [N:0] limit_q, limit_d;
  logic       periodic_q, periodic_d;
  logic [7:0] periods_q, periods_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic       accept;
  op_e        op;
  logic       at_limit;

  assign op       = op_e'(cmd_op);
  assign accept   = cmd_valid && ready_q;
  assign at_limit = (count_q == limit_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    periods_d  = periods_q;
    done_d     = 1'b0;

    if (state_q == S_LOAD) begin
      // cmd_ready is low here, so no command can interfere.
      state_d = S_RUN;
      count_d = '0;
    end else if (accept) begin
      // An accepted command wins over a terminal event on the same edge.
      unique case (op)
        OP_START: begin
          limit_d    = cmd_limit;
          periodic_d = cmd_periodic;
          count_d    = '0;
          periods_d  = '0;
          state_d    = S_LOAD;
        end
        OP_STOP: begin
          count_d = '0;
          state_d = S_IDLE;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN) state_d = S_PAUSE;
        end
        OP_RESUME: begin
          if (state_q == S_PAUSE) state_d = S_RUN;
        end
        default: ;
      endcase
    end else if (state_q == S_RUN) begin
      // Terminal compare comes before the increment, so count never wraps.
      if (!at_limit) begin
        count_d = count_q + (N+1)'(1);
      end else begin
        done_d    = 1'b1;
        periods_d = periods_q + 8'd1;
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      periods_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      periods_q  <= periods_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign periods   = periods_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, PAUSE = 2'b10, RESUME = 2'b11;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_limit = 8'd0;
  logic       cmd_periodic = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int errors = 0;
  int checks = 0;

  counter_ctrl #(.N(7)) dut (
    .clock(clock),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_limit(cmd_limit),
    .cmd_periodic(cmd_periodic),
    .count(count),
    .busy(busy),
    .done(done),
    .periods(periods)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a run is described by the number of counting steps r
  // taken since RUN began; count and periods follow from r and the limit.
  bit m_active, m_load, m_pause, m_per, m_done;
  int m_L, m_r, m_idle_count, m_periods;

  function automatic int m_count();
    if (!m_active) return m_idle_count;
    if (m_load) return 0;
    if (m_per) return m_r % (m_L + 1);
    return m_r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_load = 0; m_pause = 0; m_per = 0; m_done = 0;
    m_L = 0; m_r = 0; m_idle_count = 0; m_periods = 0;
  endtask

  task automatic model_edge(input bit acc, input logic [1:0] op, input int lim, input bit per);
    m_done = 0;
    if (acc) begin
      case (op)
        START: begin
          m_L = lim; m_per = per; m_r = 0; m_load = 1; m_pause = 0;
          m_active = 1; m_periods = 0;
        end
        STOP: begin
          m_active = 0; m_load = 0; m_pause = 0; m_idle_count = 0;
        end
        PAUSE: if (m_active && !m_load && !m_pause) m_pause = 1;
        default: if (m_pause) m_pause = 0;
      endcase
    end else if (m_load) begin
      m_load = 0;
    end else if (m_active && !m_pause) begin
      m_r++;
      if (m_per) begin
        if (m_r % (m_L + 1) == 0) begin
          m_done = 1;
          m_periods = (m_r / (m_L + 1)) % 256;
        end
      end else if (m_r == m_L + 1) begin
        m_done = 1;
        m_periods = 1;
        m_active = 0;
        m_idle_count = m_L;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", int'(count), m_count());
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
    chk("periods", int'(periods), m_periods);
    chk("cmd_ready", int'(cmd_ready), int'(!m_load));
  endtask

  // Drive one cycle of input, step the model on the edge, settle #1 after it.
  task automatic apply(input bit v, input logic [1:0] op, input int lim, input bit per);
    bit acc;
    cmd_valid = v; cmd_op = op; cmd_limit = lim[7:0]; cmd_periodic = per;
    acc = v && !m_load;
    @(posedge clock);
    model_edge(acc, op, lim, per);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_check();
    apply(0, START, 0, 0);
    check_model();
  endtask

  // Asynchronous reset pulse between edges, checked before any further edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_periods", int'(periods), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    rst = 1'b0;
  endtask

  typedef struct {
    bit v; logic [1:0] op; int lim; bit per;
    int e_count; bit e_busy; bit e_done; int e_per; bit e_rdy;
  } vec_t;

  function automatic vec_t mk(bit v, logic [1:0] op, int lim, bit per,
                              int ec, bit eb, bit ed, int ep, bit er);
    vec_t t;
    t.v = v; t.op = op; t.lim = lim; t.per = per;
    t.e_count = ec; t.e_busy = eb; t.e_done = ed; t.e_per = ep; t.e_rdy = er;
    return t;
  endfunction

  vec_t tbl[20];

  initial begin
    int done_edge, ndone, maxc, prevc, prevp;
    bit mono, wrapped;

    tbl[0]  = mk(1, START,  2, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, RESUME, 0, 0, 0, 1, 0, 0, 1);  // held in LOAD: not accepted
    tbl[2]  = mk(0, START,  0, 0, 1, 1, 0, 0, 1);
    tbl[3]  = mk(0, START,  0, 0, 2, 1, 0, 0, 1);
    tbl[4]  = mk(0, START,  0, 0, 2, 0, 1, 1, 1);
    tbl[5]  = mk(0, START,  0, 0, 2, 0, 0, 1, 1);
    tbl[6]  = mk(1, RESUME, 0, 0, 2, 0, 0, 1, 1);  // ignored in IDLE
    tbl[7]  = mk(1, START,  1, 1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, START,  0, 0, 0, 1, 0, 0, 1);
    tbl[9]  = mk(0, START,  0, 0, 1, 1, 0, 0, 1);
    tbl[10] = mk(1, STOP,   0, 0, 0, 0, 0, 0, 1);  // STOP on terminal edge
    tbl[11] = mk(1, START,  0, 1, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, START,  0, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, START,  0, 0, 0, 1, 1, 1, 1);
    tbl[14] = mk(0, START,  0, 0, 0, 1, 1, 2, 1);
    tbl[15] = mk(1, PAUSE,  0, 0, 0, 1, 0, 2, 1);
    tbl[16] = mk(0, START,  0, 0, 0, 1, 0, 2, 1);
    tbl[17] = mk(1, RESUME, 0, 0, 0, 1, 0, 2, 1);
    tbl[18] = mk(0, START,  0, 0, 0, 1, 1, 3, 1);
    tbl[19] = mk(1, STOP,   0, 0, 0, 0, 0, 3, 1);

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Table-driven vectors.
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].v, tbl[i].op, tbl[i].lim, tbl[i].per);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_count);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_periods", i), int'(periods), tbl[i].e_per);
      chk($sformatf("tbl%0d_ready", i), int'(cmd_ready), int'(tbl[i].e_rdy));
    end

    // Reset mid-RUN at count 5.
    apply(1, START, 20, 0);
    for (int i = 0; i < 6; i++) idle_check();
    chk("midrun_count5", int'(count), 5);
    do_reset();

    // One-shot, limit 10: done exactly once, 12 edges after the accept.
    apply(1, START, 10, 0);
    check_model();
    done_edge = -1; ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      idle_check();
      if (done) begin ndone++; if (done_edge < 0) done_edge = i; end
    end
    chk("oneshot_done_edge", done_edge, 12);
    chk("oneshot_ndone", ndone, 1);
    chk("oneshot_hold_count", int'(count), 10);
    chk("oneshot_busy", int'(busy), 0);
    chk("oneshot_periods", int'(periods), 1);

    // Periodic, limit 3, 1030 cycles: 257 pulses, periods wraps to 1.
    apply(1, START, 3, 1);
    check_model();
    ndone = 0; wrapped = 0; prevp = 0;
    for (int i = 1; i <= 1030; i++) begin
      idle_check();
      if (done) ndone++;
      if (prevp == 255 && periods == 8'd0) wrapped = 1;
      prevp = int'(periods);
    end
    chk("periodic_ndone", ndone, 257);
    chk("periodic_wrap_seen", int'(wrapped), 1);
    chk("periodic_final_periods", int'(periods), 1);
    apply(1, STOP, 0, 0);
    check_model();

    // Pause at count 7 for 5 edges: done moves from edge 22 to edge 27.
    apply(1, START, 20, 0);
    check_model();
    for (int i = 1; i <= 8; i++) idle_check();
    chk("pause_at7", int'(count), 7);
    apply(1, PAUSE, 0, 0);
    check_model();
    chk("paused_count", int'(count), 7);
    for (int i = 0; i < 3; i++) begin
      idle_check();
      chk("paused_count", int'(count), 7);
    end
    apply(1, RESUME, 0, 0);
    check_model();
    chk("resume_count", int'(count), 7);
    done_edge = -1;
    for (int i = 14; i <= 32; i++) begin
      idle_check();
      if (done && done_edge < 0) done_edge = i;
    end
    chk("pause_done_edge", done_edge, 27);

    // Limit 255 one-shot: reaches 255 with no wrap, then done.
    apply(1, START, 255, 0);
    check_model();
    done_edge = -1; maxc = 0; prevc = 0; mono = 1;
    for (int i = 1; i <= 260; i++) begin
      idle_check();
      if (int'(count) < prevc) mono = 0;
      if (int'(count) > maxc) maxc = int'(count);
      prevc = int'(count);
      if (done && done_edge < 0) done_edge = i;
    end
    chk("max255_reached", maxc, 255);
    chk("max255_no_wrap", int'(mono), 1);
    chk("max255_done_edge", done_edge, 257);

    // Limit 0 periodic: done every RUN cycle.
    apply(1, START, 0, 1);
    check_model();
    idle_check();
    for (int i = 0; i < 6; i++) begin
      idle_check();
      chk("lim0_done", int'(done), 1);
    end
    apply(1, STOP, 0, 0);
    check_model();

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      bit v;
      logic [1:0] op;
      int lim;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 5) == 0);
        op = 2'($urandom_range(0, 3));
        lim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        apply(v, op, lim, 1'($urandom_range(0, 1)));
        check_model();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
